bsg_expand_bitmask_serializer: RTL

- Accepts a narrow bitmask through a valid/ready handshake and expands each input bit to expand_p copies.
- Emits the expanded mask serially as fixed-width beats over a valid/yumi interface.
- Sits between a request-mask producer and a narrow write-mask consumer, for example a byte-enable path into a narrow memory port.
- Sequences one shared expander per request and holds the result until every beat has been consumed.

---
 rtl/bsg_expand_bitmask_serializer_pkg.sv | 35 +++
 rtl/bsg_expand_bitmask.sv | 19 +
 rtl/bsg_expand_bitmask_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/bsg_expand_bitmask_serializer_pkg.sv
// Shared types and helpers for bsg_expand_bitmask_serializer.
// next_nonzero_beat is only referenced when BSG_EXPAND_BITMASK_SERIALIZER_SKIP_ZERO_EN is defined.
package bsg_expand_bitmask_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Upper bound on the expanded mask width that the beat search can scan.
  localparam int max_mask_bits_lp = 256;

  // Beats needed to carry one expanded request.
  function automatic int calc_els(input int in_width, input int expand, input int beat_width);
    return (in_width * expand) / beat_width;
  endfunction

  // Lowest beat index >= start whose slice has any bit set; -1 when there is none.
  function automatic int next_nonzero_beat(input logic [max_mask_bits_lp-1:0] mask,
                                           input int beat_width,
                                           input int els,
                                           input int start);
    int found;
    found = -1;
    for (int i = els - 1; i >= 0; i--) begin
      if (i >= start) begin
        for (int b = 0; b < beat_width; b++) begin
          if (mask[i*beat_width+b]) found = i;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/bsg_expand_bitmask.sv
// Library expander: replicates each input bit expand_p times, LSB first.
module bsg_expand_bitmask #(
  parameter int in_width_p = 4,
  parameter int expand_p   = 2
) (
  input  logic [in_width_p-1:0]          i,
  output logic [in_width_p*expand_p-1:0] o
);

  // Pure combinational replication of every bit into its expand_p-wide field.
  always_comb begin
    // NOTE: a default before the loop keeps every bit assigned on every path, so no latch is inferred.
    o = '0;
    for (int j = 0; j < in_width_p; j++) begin
      o[j*expand_p +: expand_p] = {expand_p{i[j]}};
    end
  end

endmodule

// File: rtl/bsg_expand_bitmask_serializer.sv
// Expands a narrow mask and emits it as beat_width_p-wide beats over valid/yumi.
// Optional macro BSG_EXPAND_BITMASK_SERIALIZER_SKIP_ZERO_EN: skip beats whose slice is all zero.
module bsg_expand_bitmask_serializer
  import bsg_expand_bitmask_serializer_pkg::*;
#(
  parameter int in_width_p   = 4,
  parameter int expand_p     = 2,
  parameter int beat_width_p = 2,
  localparam int els_lp            = calc_els(in_width_p, expand_p, beat_width_p),
  localparam int beat_idx_width_lp = (els_lp > 1) ? $clog2(els_lp) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [in_width_p-1:0]        mask_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [beat_width_p-1:0]      mask_o,
  output logic [beat_idx_width_lp-1:0] beat_id_o,
  output logic                         last_o,
  input  logic                         yumi_i
);

  localparam int expanded_width_lp = in_width_p * expand_p;

  if ((expanded_width_lp % beat_width_p) != 0) begin : g_bad_beat_width
    $error("beat_width_p must divide in_width_p*expand_p");
  end

  state_e                         state_r, state_n;
  logic [expanded_width_lp-1:0]   expanded_r, expanded_n;
  logic [beat_idx_width_lp-1:0]   beat_r, beat_n;
  logic [expanded_width_lp-1:0]   expanded_mask;
  logic                           busy, last, accept;
  logic [beat_idx_width_lp-1:0]   first_beat, next_beat;
  logic                           first_exists;

  bsg_expand_bitmask #(
    .in_width_p(in_width_p),
    .expand_p  (expand_p)
  ) expander (
    .i(mask_i),
    .o(expanded_mask)
  );

  assign busy = (state_r == BUSY);

`ifdef BSG_EXPAND_BITMASK_SERIALIZER_SKIP_ZERO_EN
  int first_idx, next_idx;
  // Locate the first live beat of an incoming mask and the next live beat after the current one.
  always_comb begin
    first_idx    = next_nonzero_beat(max_mask_bits_lp'(expanded_mask), beat_width_p, els_lp, 0);
    next_idx     = next_nonzero_beat(max_mask_bits_lp'(expanded_r), beat_width_p, els_lp,
                                     int'(beat_r) + 1);
    first_exists = (first_idx >= 0);
    first_beat   = first_exists ? beat_idx_width_lp'(first_idx) : '0;
    last         = (next_idx < 0);
    next_beat    = last ? beat_r : beat_idx_width_lp'(next_idx);
  end
`else
  assign first_exists = 1'b1;
  assign first_beat   = '0;
  assign last         = (beat_r == beat_idx_width_lp'(els_lp - 1));
  assign next_beat    = beat_r + 1'b1;
`endif

  // The slot frees up either when idle or as the final beat is consumed.
  assign ready_o = ~reset_i & (~busy | (last & yumi_i));
  assign accept  = ready_o & v_i;

  // State register: state, captured expansion and beat counter.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (reset_i) begin
      state_r    <= IDLE;
      expanded_r <= '0;
      beat_r     <= '0;
    end else begin
      state_r    <= state_n;
      expanded_r <= expanded_n;
      beat_r     <= beat_n;
    end
  end

  // Next state: advance on yumi, retire on the last beat, capture a new mask when accepted.
  always_comb begin
    state_n    = state_r;
    expanded_n = expanded_r;
    beat_n     = beat_r;
    if (busy && yumi_i) begin
      if (last) state_n = IDLE;
      else      beat_n  = next_beat;
    end
    if (accept) begin
      expanded_n = expanded_mask;
      beat_n     = first_beat;
      state_n    = first_exists ? BUSY : IDLE;
    end
  end

  // Outputs: present the current slice while busy, all zero otherwise or in reset.
  always_comb begin
    v_o       = ~reset_i & busy;
    mask_o    = '0;
    beat_id_o = '0;
    last_o    = 1'b0;
    if (v_o) begin
      mask_o    = expanded_r[int'(beat_r)*beat_width_p +: beat_width_p];
      beat_id_o = beat_r;
      last_o    = last;
    end
  end

  // Consumer may only take a beat that is being offered.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
